// File: rtl/tsc_serial_rx.sv
// -----------------------------------------------------------------------------
// tsc_serial_rx
// Receiving end of the TriggerSurroundCache serial dump. A rising edge on trd
// starts a frame. The following sd bits are deserialised MSB-first into bytes,
// which go into a random-access buffer. cd must arrive within CD_TIMEOUT cycles
// of the last bit for the frame to count as good.
//
// Optional build macro: TSC_RX_PEAK_EN. When it is defined, the module also
// tracks the largest byte of the frame and its index.
//
// Ports
//   clk          in   single clock; all logic runs on its rising edge
//   reset_n      in   asynchronous active-low reset
//   trd          in   TSC trigger detected; a rising edge starts a frame
//   sd           in   TSC serial data, one bit per clk, MSB first
//   cd           in   TSC transfer complete
//   trigtm       in   TSC trigger timestamp
//   rd_addr      in   buffer read address
//   rd_data      out  buffer byte at rd_addr, one cycle of latency
//   byte_valid   out  one-cycle pulse when a byte has been assembled
//   byte_data    out  last assembled byte (held)
//   byte_count   out  number of bytes received in the current/last frame
//   trig_time    out  trigtm captured at the trd rising edge
//   frame_done   out  one-cycle pulse when a frame completes correctly
//   frame_err    out  framing error; stays set until the next frame starts
//   buf_ready    out  the buffer holds a complete, valid frame
//   peak_val     out  (TSC_RX_PEAK_EN) largest byte of the frame
//   peak_idx     out  (TSC_RX_PEAK_EN) index of the first occurrence of peak_val
// -----------------------------------------------------------------------------
module tsc_serial_rx #(
    parameter int N_BYTES    = 32,
    parameter int ADDR_W     = 5,
    parameter int CD_TIMEOUT = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              trd,
    input  logic              sd,
    input  logic              cd,
    input  logic [31:0]       trigtm,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              byte_valid,
    output logic [7:0]        byte_data,
    output logic [ADDR_W:0]   byte_count,
    output logic [31:0]       trig_time,
    output logic              frame_done,
    output logic              frame_err,
    output logic              buf_ready
`ifdef TSC_RX_PEAK_EN
    ,
    output logic [7:0]        peak_val,
    output logic [ADDR_W-1:0] peak_idx
`endif
);

    localparam int              TMO_W     = $clog2(CD_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(CD_TIMEOUT - 1);
    localparam logic [ADDR_W:0] COUNT_MAX = (ADDR_W + 1)'(N_BYTES);
    localparam logic [ADDR_W:0] COUNT_LAST = (ADDR_W + 1)'(N_BYTES - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, WAIT_CD} state_t;

    state_t            state_reg, state_next;
    logic              trd_q_reg;
    logic [7:0]        shift_reg;
    logic [2:0]        bit_cnt_reg;
    logic [TMO_W-1:0]  tmo_cnt_reg;
    logic [7:0]        byte_data_reg;
    logic [ADDR_W:0]   byte_count_reg;
    logic [31:0]       trig_time_reg;
    logic              byte_valid_reg, frame_done_reg, frame_err_reg, buf_ready_reg;
    logic [7:0]        rd_data_reg;
    logic [7:0]        buffer [N_BYTES];

    // Control strobes decoded from the state
    logic              rise;
    logic              start_frame, shift_en, byte_done, set_err, set_done, tmo_inc;
    logic [7:0]        new_byte;

    assign rise     = trd & ~trd_q_reg;
    assign new_byte = {shift_reg[6:0], sd};

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_reg <= IDLE;
        else          state_reg <= state_next;
    end

    // ---------------- FSM: next-state logic ----------------
    // A trd rise restarts the frame from any state. In SHIFT, cd takes priority
    // over completing the last byte.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (rise) state_next = SHIFT;
            SHIFT: begin
                if (rise)
                    state_next = SHIFT;
                else if (cd)
                    state_next = IDLE;
                else if (bit_cnt_reg == 3'd7 && byte_count_reg == COUNT_LAST)
                    state_next = WAIT_CD;
            end
            WAIT_CD: begin
                if (rise)
                    state_next = SHIFT;
                else if (cd || tmo_cnt_reg == TMO_LAST)
                    state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // ---------------- FSM: output/strobe decode ----------------
    always_comb begin
        start_frame = rise;
        shift_en    = 1'b0;
        byte_done   = 1'b0;
        set_err     = 1'b0;
        set_done    = 1'b0;
        tmo_inc     = 1'b0;
        if (!rise) begin
            case (state_reg)
                SHIFT: begin
                    if (cd) begin
                        set_err = 1'b1;
                    end else begin
                        shift_en  = 1'b1;
                        byte_done = (bit_cnt_reg == 3'd7);
                    end
                end
                WAIT_CD: begin
                    if (cd) begin
                        set_done = 1'b1;
                    end else begin
                        tmo_inc = 1'b1;
                        set_err = (tmo_cnt_reg == TMO_LAST);
                    end
                end
                default: ;
            endcase
        end
    end

    // ---------------- Datapath registers ----------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            trd_q_reg      <= 1'b0;
            shift_reg      <= '0;
            bit_cnt_reg    <= '0;
            tmo_cnt_reg    <= '0;
            byte_data_reg  <= '0;
            byte_count_reg <= '0;
            trig_time_reg  <= '0;
            byte_valid_reg <= 1'b0;
            frame_done_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            buf_ready_reg  <= 1'b0;
        end else begin
            trd_q_reg      <= trd;
            byte_valid_reg <= byte_done;
            frame_done_reg <= set_done;
            if (start_frame) begin
                trig_time_reg  <= trigtm;
                byte_count_reg <= '0;
                frame_err_reg  <= 1'b0;
                buf_ready_reg  <= 1'b0;
                shift_reg      <= '0;
                bit_cnt_reg    <= '0;
                tmo_cnt_reg    <= '0;
            end else begin
                if (shift_en) begin
                    shift_reg   <= new_byte;
                    bit_cnt_reg <= bit_cnt_reg + 3'd1;
                end
                if (byte_done) begin
                    byte_data_reg <= new_byte;
                    if (byte_count_reg != COUNT_MAX)
                        byte_count_reg <= byte_count_reg + 1'b1;
                    tmo_cnt_reg <= '0;
                end
                if (tmo_inc) tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
                if (set_err) frame_err_reg <= 1'b1;
                if (set_done) buf_ready_reg <= 1'b1;
            end
        end
    end

    // ---------------- Frame buffer ----------------
    // Plain write port with no reset so it maps onto block RAM; a read of an
    // address being written returns the previous byte.
    always_ff @(posedge clk) begin
        if (byte_done)
            buffer[byte_count_reg[ADDR_W-1:0]] <= new_byte;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            rd_data_reg <= '0;
        else if ({1'b0, rd_addr} < COUNT_MAX)
            rd_data_reg <= buffer[rd_addr];
        else
            rd_data_reg <= '0;
    end

`ifdef TSC_RX_PEAK_EN
    // Strict greater-than keeps the first index on ties.
    logic [7:0]        peak_val_reg;
    logic [ADDR_W-1:0] peak_idx_reg;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            peak_val_reg <= '0;
            peak_idx_reg <= '0;
        end else if (start_frame) begin
            peak_val_reg <= '0;
            peak_idx_reg <= '0;
        end else if (byte_done && new_byte > peak_val_reg) begin
            peak_val_reg <= new_byte;
            peak_idx_reg <= byte_count_reg[ADDR_W-1:0];
        end
    end

    assign peak_val = peak_val_reg;
    assign peak_idx = peak_idx_reg;
`endif

    assign rd_data    = rd_data_reg;
    assign byte_valid = byte_valid_reg;
    assign byte_data  = byte_data_reg;
    assign byte_count = byte_count_reg;
    assign trig_time  = trig_time_reg;
    assign frame_done = frame_done_reg;
    assign frame_err  = frame_err_reg;
    assign buf_ready  = buf_ready_reg;

endmodule

// File: tb/tb_tsc_serial_rx.sv
// -----------------------------------------------------------------------------
// tb_tsc_serial_rx
// Directed bench for tsc_serial_rx. Inputs are driven on the falling clock
// edge and outputs are sampled on the falling edge, half a period away from
// the active rising edge. Define TSC_RX_PEAK_EN to include the peak test.
// -----------------------------------------------------------------------------
module tb_tsc_serial_rx;

    localparam int N_BYTES = 32;
    localparam int ADDR_W  = 5;

    logic              clk = 1'b0;
    logic              reset_n;
    logic              trd, sd, cd;
    logic [31:0]       trigtm;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              byte_valid;
    logic [7:0]        byte_data;
    logic [ADDR_W:0]   byte_count;
    logic [31:0]       trig_time;
    logic              frame_done, frame_err, buf_ready;
`ifdef TSC_RX_PEAK_EN
    logic [7:0]        peak_val;
    logic [ADDR_W-1:0] peak_idx;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    int bv_cnt   = 0;
    int fd_cnt   = 0;
    int bv_base, fd_base;

    always #5 clk = ~clk;

    tsc_serial_rx #(.N_BYTES(N_BYTES), .ADDR_W(ADDR_W), .CD_TIMEOUT(4)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .trd        (trd),
        .sd         (sd),
        .cd         (cd),
        .trigtm     (trigtm),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_count (byte_count),
        .trig_time  (trig_time),
        .frame_done (frame_done),
        .frame_err  (frame_err),
        .buf_ready  (buf_ready)
`ifdef TSC_RX_PEAK_EN
        ,
        .peak_val   (peak_val),
        .peak_idx   (peak_idx)
`endif
    );

    // Pulse counters; each pulse is counted once at the rising edge that ends it
    always @(posedge clk) begin
        if (byte_valid === 1'b1) bv_cnt++;
        if (frame_done === 1'b1) fd_cnt++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int kind, input int i);
        case (kind)
            0:       return (i % 2 == 0) ? 8'hD7 : 8'h00;
            1:       return 8'((i * 3 + 1) & 255);
            2:       return (i % 2 == 1) ? 8'hF0 : 8'((((i / 2) % 14) + 1) * 16);
            default: return 8'(255 - i);
        endcase
    endfunction

    task automatic start_frame(input logic [31:0] t);
        @(negedge clk); trd = 1'b0;
        @(negedge clk); trigtm = t; trd = 1'b1; cd = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            @(negedge clk); sd = b[i];
        end
    endtask

    task automatic send_frame(input int kind, input int nb);
        for (int i = 0; i < nb; i++) send_byte(pat(kind, i));
    endtask

    task automatic rd_check(input logic [ADDR_W-1:0] a, input logic [7:0] exp, input string tag);
        @(negedge clk); rd_addr = a;
        @(negedge clk); chk(tag, 32'(rd_data), 32'(exp));
    endtask

    initial begin
        logic [7:0] b;
        reset_n = 1'b0; trd = 1'b0; sd = 1'b0; cd = 1'b0; trigtm = '0; rd_addr = '0;
        #1;
        chk("rst_byte_count", 32'(byte_count), 32'd0);
        chk("rst_flags", {28'd0, byte_valid, frame_done, frame_err, buf_ready}, 32'd0);
        chk("rst_trig_time", trig_time, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // ---- Reset in the middle of SHIFT after 12 bits ----
        start_frame(32'h0000_0055);
        send_byte(8'hA5);
        b = 8'h3C;
        for (int i = 7; i >= 4; i--) begin @(negedge clk); sd = b[i]; end
        @(negedge clk);
        chk("t1_pre_count", 32'(byte_count), 32'd1);
        chk("t1_pre_data", 32'(byte_data), 32'hA5);
        #2 reset_n = 1'b0; trd = 1'b0;
        #1;
        chk("t1_async_count", 32'(byte_count), 32'd0);
        chk("t1_async_data", 32'(byte_data), 32'd0);
        chk("t1_async_trig", trig_time, 32'd0);
        @(negedge clk); reset_n = 1'b1;

        // ---- Good frame, D7/00 alternating, cd one cycle after last bit ----
        bv_base = bv_cnt; fd_base = fd_cnt;
        start_frame(32'h0000_0100);
        send_frame(0, N_BYTES);
        @(negedge clk); cd = 1'b1;
        @(negedge clk);
        chk("t2_frame_done", 32'(frame_done), 32'd1);
        chk("t2_buf_ready", 32'(buf_ready), 32'd1);
        cd = 1'b0;
        @(negedge clk);
        chk("t2_done_pulse", 32'(frame_done), 32'd0);
        chk("t2_frame_err", 32'(frame_err), 32'd0);
        chk("t2_trig_time", trig_time, 32'h100);
        chk("t2_byte_count", 32'(byte_count), 32'd32);
        chk("t2_byte_data", 32'(byte_data), 32'h00);
        rd_check(5'd0, 8'hD7, "t2_rd0");
        rd_check(5'd1, 8'h00, "t2_rd1");
        rd_check(5'd30, 8'hD7, "t2_rd30");
        chk("t2_bv_pulses", 32'(bv_cnt - bv_base), 32'd32);
        chk("t2_fd_pulses", 32'(fd_cnt - fd_base), 32'd1);

        // ---- Early cd after 20 bits ----
        fd_base = fd_cnt;
        start_frame(32'h0000_0200);
        send_byte(8'h11);
        send_byte(8'h22);
        b = 8'h33;
        for (int i = 7; i >= 4; i--) begin @(negedge clk); sd = b[i]; end
        @(negedge clk); cd = 1'b1;
        @(negedge clk);
        chk("t3_frame_err", 32'(frame_err), 32'd1);
        chk("t3_byte_count", 32'(byte_count), 32'd2);
        chk("t3_buf_ready", 32'(buf_ready), 32'd0);
        // cd held high in IDLE is ignored; the error stays sticky
        repeat (2) @(negedge clk);
        cd = 1'b0;
        chk("t3_err_sticky", 32'(frame_err), 32'd1);
        rd_check(5'd1, 8'h22, "t3_rd1_partial");
        chk("t3_no_done", 32'(fd_cnt - fd_base), 32'd0);

        // ---- Full frame, cd never arrives: timeout after 4 cycles ----
        fd_base = fd_cnt;
        start_frame(32'h0000_0300);
        send_frame(1, N_BYTES);
        repeat (4) @(negedge clk);
        chk("t4_err_before_tmo", 32'(frame_err), 32'd0);
        @(negedge clk);
        chk("t4_err_at_tmo", 32'(frame_err), 32'd1);
        chk("t4_buf_ready", 32'(buf_ready), 32'd0);
        @(negedge clk);
        chk("t4_no_done", 32'(fd_cnt - fd_base), 32'd0);

        // ---- cd on the last bit of the last byte is an early cd ----
        fd_base = fd_cnt;
        start_frame(32'h0000_0350);
        send_frame(1, N_BYTES - 1);
        b = pat(1, N_BYTES - 1);
        for (int i = 7; i >= 1; i--) begin @(negedge clk); sd = b[i]; end
        @(negedge clk); sd = b[0]; cd = 1'b1;
        @(negedge clk); cd = 1'b0;
        chk("t4b_frame_err", 32'(frame_err), 32'd1);
        chk("t4b_buf_ready", 32'(buf_ready), 32'd0);
        repeat (6) @(negedge clk);
        chk("t4b_no_done", 32'(fd_cnt - fd_base), 32'd0);

        // ---- Second trd rise during byte 5 restarts the frame ----
        fd_base = fd_cnt;
        start_frame(32'h0000_0380);
        send_frame(1, 5);
        b = 8'hE3;
        for (int i = 7; i >= 5; i--) begin @(negedge clk); sd = b[i]; end
        start_frame(32'h0000_0400);
        @(posedge clk); #1;
        chk("t5_count_restart", 32'(byte_count), 32'd0);
        chk("t5_trig_time", trig_time, 32'h400);
        chk("t5_no_err", 32'(frame_err), 32'd0);
        send_frame(3, N_BYTES);
        @(negedge clk); cd = 1'b1;
        @(negedge clk); cd = 1'b0;
        chk("t5_frame_done", 32'(frame_done), 32'd1);
        chk("t5_buf_ready", 32'(buf_ready), 32'd1);
        chk("t5_byte_count", 32'(byte_count), 32'd32);
        rd_check(5'd5, 8'hFA, "t5_rd5");
        rd_check(5'd31, 8'hE0, "t5_rd31");
        chk("t5_fd_pulses", 32'(fd_cnt - fd_base), 32'd1);

`ifdef TSC_RX_PEAK_EN
        // ---- Peak tracking: 0x10,0xF0,0x20,0xF0,... ----
        start_frame(32'h0000_0500);
        send_frame(2, N_BYTES);
        @(negedge clk); cd = 1'b1;
        @(negedge clk); cd = 1'b0;
        chk("t6_buf_ready", 32'(buf_ready), 32'd1);
        chk("t6_peak_val", 32'(peak_val), 32'hF0);
        chk("t6_peak_idx", 32'(peak_idx), 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no end of test, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
